// File: rtl/cache_pkg.sv
// Shared encodings for the cache refill path: FSM states, AHB-Lite codes
// and the address split used to form line index and tag.
package cache_pkg;
    localparam int TAG_WIDTH              = 22;
    localparam int LOG2_BLOCK_SIZE        = 5;
    localparam int LOG2_BLOCK_WIDTH_WORDS = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_BURST = 2'd2,
        S_WRITE = 2'd3
    } refill_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR8 = 3'b101;
    localparam logic [2:0] HSIZE_WORD   = 3'b010;
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// AHB-Lite read-master bundle between the refill controller and the bus.
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic [WORD_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HTRANS, HBURST, HSIZE, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HBURST, HSIZE, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/refill_line_buffer.sv
// Assembles one cache line from individually written bus words.
module refill_line_buffer #(
    parameter int WORD_WIDTH        = 32,
    parameter int BLOCK_WIDTH_WORDS = 8,
    parameter int SEL_WIDTH         = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  we,
    input  logic [SEL_WIDTH-1:0]                  sel,
    input  logic [WORD_WIDTH-1:0]                 data,
    output logic [WORD_WIDTH*BLOCK_WIDTH_WORDS-1:0] line
);
    logic [BLOCK_WIDTH_WORDS-1:0][WORD_WIDTH-1:0] words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            words <= '0;
        else if (we)
            words[sel] <= data;
    end

    assign line = words;
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill over an AHB-Lite INCR8 read burst; assembles the line
// and presents it with a one-cycle write strobe, or reports a bus error.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH             = 32,
    parameter int WORD_WIDTH             = 32,
    parameter int BLOCK_WIDTH_WORDS      = 8,
    parameter int LOG2_BLOCK_WIDTH_WORDS = cache_pkg::LOG2_BLOCK_WIDTH_WORDS,
    parameter int LOG2_BLOCK_SIZE        = cache_pkg::LOG2_BLOCK_SIZE,
    parameter int TAG_WIDTH              = cache_pkg::TAG_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    miss_req,
    input  logic [ADDR_WIDTH-1:0]                   miss_addr,
    output logic                                    miss_ack,
    output logic                                    line_we,
    output logic [LOG2_BLOCK_SIZE-1:0]              line_index,
    output logic [TAG_WIDTH-1:0]                    line_tag,
    output logic [WORD_WIDTH*BLOCK_WIDTH_WORDS-1:0] line_data,
    output logic                                    fill_done,
    output logic                                    fill_err,
    cache_refill_ctrl_if.master                     ahb
);
    import cache_pkg::*;

    localparam int OFS  = LOG2_BLOCK_WIDTH_WORDS + $clog2(WORD_WIDTH / 8);
    localparam int LA_W = ADDR_WIDTH - OFS;
    localparam logic [LOG2_BLOCK_WIDTH_WORDS-1:0] LAST =
        LOG2_BLOCK_WIDTH_WORDS'(BLOCK_WIDTH_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WORD_WIDTH / 8);

    refill_state_t state, state_nxt;
    logic [LA_W-1:0]                   addr_q;
    logic [ADDR_WIDTH-1:0]             haddr_q;
    logic [LOG2_BLOCK_WIDTH_WORDS-1:0] acnt, dcnt;
    logic                              addr_done;
    logic [1:0]                        htrans;
    logic                              beat_ok, abort;
    logic [BLOCK_WIDTH_WORDS-1:0][WORD_WIDTH-1:0] buf_line, next_line, line_q;

    // In BURST exactly one data phase is always outstanding, so a single
    // HREADY both retires a data beat and accepts the next address beat.
    assign beat_ok = (state == S_BURST) && ahb.HREADY && !ahb.HRESP;
    assign abort   = (state == S_BURST) && ahb.HRESP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        htrans    = HTRANS_IDLE;
        case (state)
            S_IDLE:  if (miss_req) state_nxt = S_ADDR;
            S_ADDR: begin
                htrans = HTRANS_NONSEQ;
                if (ahb.HREADY) state_nxt = S_BURST;
            end
            S_BURST: begin
                if (!addr_done) htrans = HTRANS_SEQ;
                if (abort)                       state_nxt = S_IDLE;
                else if (beat_ok && dcnt == LAST) state_nxt = S_WRITE;
            end
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        next_line                      = buf_line;
        next_line[BLOCK_WIDTH_WORDS-1] = ahb.HRDATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            haddr_q    <= '0;
            acnt       <= '0;
            dcnt       <= '0;
            addr_done  <= 1'b0;
            line_index <= '0;
            line_tag   <= '0;
            line_q     <= '0;
            fill_err   <= 1'b0;
        end else begin
            fill_err <= abort;
            case (state)
                S_IDLE: if (miss_req) begin
                    addr_q    <= miss_addr[ADDR_WIDTH-1:OFS];
                    haddr_q   <= {miss_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                    acnt      <= '0;
                    dcnt      <= '0;
                    addr_done <= 1'b0;
                end
                S_ADDR: if (ahb.HREADY) begin
                    haddr_q <= haddr_q + STEP;
                    acnt    <= acnt + 1'b1;
                end
                S_BURST: if (beat_ok) begin
                    if (!addr_done) begin
                        if (acnt == LAST) addr_done <= 1'b1;
                        else begin
                            acnt    <= acnt + 1'b1;
                            haddr_q <= haddr_q + STEP;
                        end
                    end
                    // Output line only changes on a complete fill; partial
                    // lines never reach line_data.
                    if (dcnt == LAST) begin
                        line_q     <= next_line;
                        line_index <= addr_q[LOG2_BLOCK_SIZE-1:0];
                        line_tag   <= addr_q[LA_W-1 -: TAG_WIDTH];
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    refill_line_buffer #(
        .WORD_WIDTH(WORD_WIDTH),
        .BLOCK_WIDTH_WORDS(BLOCK_WIDTH_WORDS),
        .SEL_WIDTH(LOG2_BLOCK_WIDTH_WORDS)
    ) u_buf (
        .clk(clk),
        .rst(rst),
        .we(beat_ok),
        .sel(dcnt),
        .data(ahb.HRDATA),
        .line(buf_line)
    );

    assign miss_ack   = (state == S_IDLE) && miss_req && !rst;
    assign line_we    = (state == S_WRITE);
    assign fill_done  = (state == S_WRITE);
    assign line_data  = line_q;
    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans;
    assign ahb.HBURST = HBURST_INCR8;
    assign ahb.HSIZE  = HSIZE_WORD;
    assign ahb.HWRITE = 1'b0;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed refills against an AHB
// slave model with programmable wait, error and mid-burst reset.
module tb_cache_refill_ctrl;
    logic         clk;
    logic         rst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_ack;
    logic         line_we;
    logic [4:0]   line_index;
    logic [21:0]  line_tag;
    logic [255:0] line_data;
    logic         fill_done;
    logic         fill_err;

    cache_refill_ctrl_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) ahb ();

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_ack(miss_ack), .line_we(line_we), .line_index(line_index),
        .line_tag(line_tag), .line_data(line_data), .fill_done(fill_done),
        .fill_err(fill_err), .ahb(ahb.master)
    );

    typedef struct { logic [1:0] tr; logic [31:0] a; } abeat_t;
    typedef struct { bit err; logic [4:0] idx; logic [21:0] tag; logic [255:0] line; int lat; } evt_t;

    abeat_t aq[$];
    evt_t   eq[$];
    int     ack_cyc[$];
    int     evt_cnt = 0;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;

    // slave model controls
    logic [31:0] dbase = 32'h0;
    int wait_beat = -1, wait_left = 0, err_beat = -1;
    bit dp_on = 0;
    int dp_beat = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // AHB slave: data phase follows an accepted address phase by one cycle
    initial begin
        logic [1:0]  s_tr;
        logic        s_rdy, s_resp;
        logic [31:0] s_a;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
        ahb.HRDATA = 32'h0;
        forever begin
            @(negedge clk);
            s_tr = ahb.HTRANS; s_rdy = ahb.HREADY; s_resp = ahb.HRESP; s_a = ahb.HADDR;
            @(posedge clk);
            #1;
            if (rst) dp_on = 0;
            else if (s_rdy) begin
                if (s_resp) dp_on = 0;
                else begin
                    dp_on   = (s_tr != 2'b00);
                    dp_beat = int'(s_a[4:2]);
                end
            end
            ahb.HRESP = 1'b0;
            if (dp_on && dp_beat == wait_beat && wait_left > 0) begin
                ahb.HREADY = 1'b0;
                ahb.HRDATA = 32'hBAD0_0000;
                wait_left--;
            end else begin
                ahb.HREADY = 1'b1;
                ahb.HRDATA = dp_on ? dbase + 32'(dp_beat) : 32'hDEAD_BEEF;
                if (dp_on && dp_beat == err_beat) begin
                    ahb.HRESP = 1'b1;
                    err_beat  = -1;
                end
            end
        end
    end

    // monitor / scoreboard
    initial begin
        bit     hold_chk;
        abeat_t held, e;
        evt_t   ev;
        int     lat;
        hold_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 0;
                continue;
            end
            if (hold_chk) begin
                chk("hold_htrans", ahb.HTRANS, held.tr);
                chk("hold_haddr", ahb.HADDR, held.a);
                hold_chk = 0;
            end
            if (ahb.HTRANS != 2'b00) begin
                chk("ahb_ctrl", {ahb.HBURST, ahb.HSIZE, ahb.HWRITE}, {3'b101, 3'b010, 1'b0});
                if (ahb.HREADY) begin
                    if (aq.size() == 0) chk("addr_extra", ahb.HADDR, 32'hFFFF_FFFF ^ ahb.HADDR);
                    else begin
                        e = aq.pop_front();
                        chk("addr_htrans", ahb.HTRANS, e.tr);
                        chk("addr_haddr", ahb.HADDR, e.a);
                    end
                end else begin
                    hold_chk = 1;
                    held.tr  = ahb.HTRANS;
                    held.a   = ahb.HADDR;
                end
            end
            if (miss_ack) ack_cyc.push_back(cyc);
            if (line_we || fill_err) begin
                evt_cnt++;
                if (eq.size() == 0) chk("evt_extra", {line_we, fill_err}, 2'b00);
                else begin
                    ev = eq.pop_front();
                    chk("evt_kind", {line_we, fill_done, fill_err}, ev.err ? 3'b001 : 3'b110);
                    if (ev.err) chk("err_htrans", ahb.HTRANS, 2'b00);
                    else begin
                        lat = (ack_cyc.size() > 0) ? cyc - ack_cyc[$] : -1;
                        chk("line_index", line_index, ev.idx);
                        chk("line_tag", line_tag, ev.tag);
                        chk("line_data", line_data, ev.line);
                        chk("latency", lat, ev.lat);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_htrans"}, ahb.HTRANS, 2'b00);
        chk({tag, "_haddr"}, ahb.HADDR, 32'h0);
        chk({tag, "_line_data"}, line_data, 256'h0);
        chk({tag, "_idx_tag"}, {line_index, line_tag}, 27'h0);
        chk({tag, "_pulses"}, {miss_ack, line_we, fill_done, fill_err}, 4'b0000);
    endtask

    task automatic push_fill(input logic [31:0] aligned, input logic [4:0] idx, input logic [21:0] tag,
                             input logic [31:0] base, input int nbeats, input bit err, input bit has_evt,
                             input int lat);
        abeat_t b;
        evt_t   ev;
        for (int k = 0; k < nbeats; k++) begin
            b.tr = (k == 0) ? 2'b10 : 2'b11;
            b.a  = aligned + 32'(4 * k);
            aq.push_back(b);
        end
        for (int k = 0; k < 8; k++) ev.line[32*k +: 32] = base + 32'(k);
        ev.err = err; ev.idx = idx; ev.tag = tag; ev.lat = lat;
        if (has_evt) eq.push_back(ev);
    endtask

    task automatic refill(input logic [31:0] addr, input logic [31:0] aligned, input logic [4:0] idx,
                          input logic [21:0] tag, input logic [31:0] base, input int wbeat, input int wn,
                          input int ebeat, input int rbeat, input int lat);
        int nbeats, start;
        bit got, done;
        nbeats = (ebeat >= 0) ? ebeat + 2 : (rbeat >= 0) ? rbeat + 2 : 8;
        push_fill(aligned, idx, tag, base, nbeats, ebeat >= 0, rbeat < 0, lat);
        dbase = base; wait_beat = wbeat; wait_left = wn; err_beat = ebeat;
        @(posedge clk);
        #1;
        miss_addr = addr;
        miss_req  = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #2;
            if (miss_ack) got = 1;
        end
        if (!got) chk("ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        miss_req = 1'b0;
        start = evt_cnt;
        done  = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #2;
            if (rbeat >= 0 && dp_on && dp_beat == rbeat && ahb.HREADY) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("midrst");
                @(posedge clk);
                @(negedge clk);
                #2;
                rst = 1'b0;
                wait_left = 0;
                err_beat  = -1;
                done = 1;
            end else if (evt_cnt != start) done = 1;
        end
        if (!done) chk("refill_timeout", 0, 1);
    endtask

    initial begin
        int start;
        bit done;
        logic [255:0] prev_line;
        rst = 1'b1; miss_req = 1'b0; miss_addr = 32'h0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // zero-wait refill
        refill(32'h0000_1234, 32'h0000_1220, 5'h11, 22'h000004, 32'hA0, -1, 0, -1, -1, 10);
        // two wait states on data beat 3
        refill(32'h0000_2468, 32'h0000_2460, 5'h03, 22'h000009, 32'hB0, 3, 2, -1, -1, 12);
        for (int k = 0; k < 8; k++) prev_line[32*k +: 32] = 32'hB0 + 32'(k);
        // error on data beat 4: old line stays, then retry succeeds
        refill(32'h0000_4000, 32'h0000_4000, 5'h00, 22'h000010, 32'hC0, -1, 0, 4, -1, 0);
        chk("err_keeps_line", line_data, prev_line);
        chk("err_keeps_idx", {line_index, line_tag}, {5'h03, 22'h000009});
        refill(32'h0000_4000, 32'h0000_4000, 5'h00, 22'h000010, 32'hC0, -1, 0, -1, -1, 10);
        // reset on data beat 5, then a fill to the top line
        refill(32'h0000_8000, 32'h0000_8000, 5'h00, 22'h000020, 32'hD0, -1, 0, -1, 5, 0);
        refill(32'hFFFF_FFE0, 32'hFFFF_FFE0, 5'h1F, 22'h3FFFFF, 32'hE0, -1, 0, -1, -1, 10);

        // miss_req held across a whole refill
        ack_cyc.delete();
        push_fill(32'h40, 5'h02, 22'h0, 32'h10, 8, 0, 1, 10);
        push_fill(32'h40, 5'h02, 22'h0, 32'h10, 8, 0, 1, 10);
        dbase = 32'h10;
        @(posedge clk);
        #1;
        miss_addr = 32'h0000_0040;
        miss_req  = 1'b1;
        start = evt_cnt;
        done  = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            #2;
            if (evt_cnt == start + 2) begin
                miss_req = 1'b0;
                done = 1;
            end
        end
        if (!done) chk("held_timeout", 0, 1);
        chk("held_ack_count", ack_cyc.size(), 2);
        if (ack_cyc.size() == 2) chk("held_ack_gap", ack_cyc[1] - ack_cyc[0], 11);

        // back-to-back misses
        refill(32'h0000_0000, 32'h0000_0000, 5'h00, 22'h0, 32'h20, -1, 0, -1, -1, 10);
        refill(32'h0000_0020, 32'h0000_0020, 5'h01, 22'h0, 32'h30, -1, 0, -1, -1, 10);

        repeat (3) @(negedge clk);
        chk("addr_q_empty", aq.size(), 0);
        chk("evt_q_empty", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH=32, byte address width; WORD_WIDTH=32, AHB data width; BLOCK_WIDTH_WORDS=8, words per line; LOG2_BLOCK_WIDTH_WORDS=3; LOG2_BLOCK_SIZE=5, line index width; TAG_WIDTH=22.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_req  in  1  cache requests a line refill.
- miss_addr  in  ADDR_WIDTH  missing byte address.
- miss_ack  out  1  one-cycle pulse when the request is accepted.
- line_we  out  1  one-cycle write strobe to the line SSRAM and tag/valid arrays.
- line_index  out  LOG2_BLOCK_SIZE  SSRAM address, miss_addr[9:5].
- line_tag  out  TAG_WIDTH  tag, miss_addr[31:10].
- line_data  out  WORD_WIDTH*BLOCK_WIDTH_WORDS  assembled line; word k at bits [32k+31:32k].
- fill_done  out  1  one-cycle pulse, coincident with line_we.
- fill_err  out  1  one-cycle pulse when the burst is aborted on error.
- HADDR  out  ADDR_WIDTH;  HTRANS  out  2;  HBURST  out  3;  HSIZE  out  3;  HWRITE  out  1.
- HRDATA  in  WORD_WIDTH;  HREADY  in  1;  HRESP  in  1.

Function
REQ-003 SHALL implement states IDLE, ADDR, BURST, WRITE.
REQ-004 IDLE SHALL sample miss_req each cycle. When miss_req=1 it SHALL:
- latch miss_addr;
- pulse miss_ack;
- go to ADDR.
REQ-005 miss_req SHALL be ignored outside IDLE. No queuing. miss_ack SHALL stay 0.
REQ-006 ADDR SHALL drive HTRANS=NONSEQ(2'b10) and HADDR={latched addr[31:5],5'b0}. On HREADY=1 it SHALL go to BURST.
REQ-007 BURST SHALL drive HTRANS=SEQ(2'b11) for address beats 1..7. HADDR SHALL increase by 4 on each cycle with HREADY=1.
REQ-008 After the 8th address beat is accepted, HTRANS SHALL be IDLE(2'b00) while remaining data beats complete.
REQ-009 HADDR and HTRANS SHALL hold stable while HREADY=0.
REQ-010 A data beat SHALL be captured only when HREADY=1 in its data phase, one cycle after its address phase was accepted. Beat k SHALL go into line word k.
REQ-011 A 3-bit address-beat counter and a 3-bit data-beat counter SHALL be kept independently. Neither SHALL wrap within a burst.
REQ-012 After data beat 7 is captured, the block SHALL enter WRITE. WRITE SHALL last exactly one cycle with line_we=1 and fill_done=1, then return to IDLE.
REQ-013 With zero wait states, line_we SHALL assert 10 cycles after the miss_ack cycle. Each HREADY=0 cycle in the burst SHALL add exactly one cycle.
REQ-014 HRESP=1 during any data phase SHALL:
- force HTRANS=IDLE from the next cycle;
- discard the partial line; line_we SHALL not assert;
- pulse fill_err once;
- return to IDLE.
REQ-015 HBURST SHALL be constant INCR8 (3'b101), HSIZE constant word (3'b010), HWRITE constant 0.
REQ-016 line_index, line_tag and line_data SHALL hold their values from the end of WRITE until the next WRITE.
REQ-017 If miss_req=1 in the same cycle as WRITE, it SHALL be ignored. It SHALL be accepted in the following IDLE cycle if still asserted.

Reset
REQ-018 On rst=1, asynchronously:
- state=IDLE; both counters=0; latched address=0;
- HTRANS=IDLE; HADDR=0; line_data=0; line_index=0; line_tag=0;
- miss_ack=0; line_we=0; fill_done=0; fill_err=0.
REQ-019 Reset mid-burst SHALL abandon the burst with no line_we and no fill_err. The first post-reset request SHALL start a fresh NONSEQ.

Structure
REQ-020 A shared package cache_pkg SHALL hold:
- state encodings;
- HTRANS codes IDLE/NONSEQ/SEQ;
- HBURST_INCR8 and HSIZE_WORD;
- address-split widths (TAG_WIDTH, LOG2_BLOCK_SIZE, LOG2_BLOCK_WIDTH_WORDS).
REQ-021 Line assembly SHALL be one sub-module, refill_line_buffer. Inputs: clk, rst, word write enable, 3-bit word select, data. Output: the 256-bit line.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Zero-wait refill, miss_addr=0x0000_1234:
  - HADDR sequence 0x1220..0x123C with HTRANS NONSEQ then SEQ x7;
  - HRDATA=0xA0+k gives line word k=0xA0+k;
  - line_index=0x11, line_tag=0x000004;
  - line_we 10 cycles after miss_ack.
- HREADY=0 for 2 cycles on beat 3: HADDR/HTRANS held; line_we at cycle 12; line data unchanged.
- HRESP=1 on data beat 4: HTRANS=IDLE next cycle; one fill_err pulse; no line_we; next refill succeeds.
- rst asserted on data beat 5: outputs reach reset values immediately with no clk edge; no line_we; a subsequent miss to 0xFFFF_FFE0 fills index 0x1F, tag 0x3FFFFF.
- miss_req held high throughout a refill: exactly one miss_ack per refill; a second miss_ack the cycle after WRITE.
- Back-to-back misses to 0x0000_0000 then 0x0000_0020: the first HADDR of the second burst is 0x0000_0020.
